ghost_swarm_unit: RTL and testbench



---
 rtl/ghost_swarm_if.sv | 36 +++
 rtl/ghost_swarm_unit.sv | 225 ++++++++++++++++++++++
 tb/tb_ghost_swarm_unit.sv | 429 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ghost_swarm_if.sv
// Bus between the pixel counter / collision logic and the ghost swarm.
// Handshake: there is no valid/ready. startOfFrame is a one-cycle strobe,
// collision is a per-ghost one-cycle pulse, and the pixel coordinates are a
// free-running stream sampled every clock. Each pixel result appears on the
// outputs exactly one clock after its pxl_x/pxl_y.
interface ghost_swarm_if #(
    parameter int N_GHOSTS = 4
);
    logic                      startOfFrame;
    logic                      freeze;
    logic [N_GHOSTS-1:0]       collision;
    logic [10:0]               pxl_x;
    logic [10:0]               pxl_y;
    logic [11:0]               wheel;

    logic                      Draw;
    logic [2:0]                ghost_idx;
    logic [9:0]                local_x;
    logic [8:0]                local_y;
    logic [9:0]                theta;
    logic [3:0]                Red;
    logic [3:0]                Green;
    logic [3:0]                Blue;
    // Two bits of life-cycle state per ghost, ghost i at [2*i +: 2].
    logic [2*N_GHOSTS-1:0]     ghost_state;

    modport master (
        output startOfFrame, freeze, collision, pxl_x, pxl_y, wheel,
        input  Draw, ghost_idx, local_x, local_y, theta, Red, Green, Blue, ghost_state
    );

    modport slave (
        input  startOfFrame, freeze, collision, pxl_x, pxl_y, wheel,
        output Draw, ghost_idx, local_x, local_y, theta, Red, Green, Blue, ghost_state
    );
endinterface

// File: rtl/ghost_swarm_unit.sv
// Multi-ghost sprite engine. Each ghost bounces around the playfield and runs
// an ALIVE/HIT/DEAD/RESPAWN life cycle driven by collision pulses. The pixel
// path picks the lowest-index ghost covering the current pixel and registers
// its index, sprite-local coordinates and colour. theta is a frame-stable
// rotation angle derived from the wheel input.
module ghost_swarm_unit #(
    parameter int          N_GHOSTS     = 4,
    parameter int          W            = 64,
    parameter int          H            = 64,
    parameter int          X_MIN        = 0,
    parameter int          X_MAX        = 639,
    parameter int          Y_MIN        = 0,
    parameter int          Y_MAX        = 479,
    parameter int          SPEED_X      = 2,
    parameter int          SPEED_Y      = 1,
    parameter int          SPAWN_X0     = 32,
    parameter int          SPAWN_STEP   = 128,
    parameter int          FLASH_FRAMES = 16,
    parameter int          DEAD_FRAMES  = 60,
    parameter int          WHEEL_MUL    = 34,
    parameter logic [11:0] COLOR        = 12'hF0F
) (
    input  logic          clk,
    input  logic          resetN,
    ghost_swarm_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_ALIVE   = 2'd0,
        ST_HIT     = 2'd1,
        ST_DEAD    = 2'd2,
        ST_RESPAWN = 2'd3
    } life_t;

    // Positions live in 12-bit signed space so a step past X_MIN/Y_MIN shows
    // up as a negative number instead of wrapping.
    localparam logic signed [11:0] X_LO    = 12'(X_MIN);
    localparam logic signed [11:0] X_HI    = 12'(X_MAX - W + 1);
    localparam logic signed [11:0] Y_LO    = 12'(Y_MIN);
    localparam logic signed [11:0] Y_HI    = 12'(Y_MAX - H + 1);
    localparam logic signed [11:0] SPD_X   = 12'(SPEED_X);
    localparam logic signed [11:0] SPD_Y   = 12'(SPEED_Y);
    localparam logic signed [11:0] W_S     = 12'(W);
    localparam logic signed [11:0] H_S     = 12'(H);
    localparam logic signed [11:0] SPAWN_Y = 12'(Y_MIN + 16);
    localparam logic [7:0]         FLASH_LAST = 8'(FLASH_FRAMES - 1);
    localparam logic [7:0]         DEAD_LAST  = 8'(DEAD_FRAMES - 1);

    logic                 frame_tick;
    logic signed [11:0]   px;
    logic signed [11:0]   py;

    logic [N_GHOSTS-1:0]  hit;
    logic [9:0]           lx_w  [N_GHOSTS];
    logic [8:0]           ly_w  [N_GHOSTS];
    logic [11:0]          rgb_w [N_GHOSTS];
    logic [2*N_GHOSTS-1:0] state_dbg;

    assign frame_tick = bus.startOfFrame & ~bus.freeze;
    assign px = signed'({1'b0, bus.pxl_x});
    assign py = signed'({1'b0, bus.pxl_y});

    for (genvar g = 0; g < N_GHOSTS; g++) begin : g_ghost
        localparam logic signed [11:0] SPAWN_X = 12'(SPAWN_X0 + g * SPAWN_STEP);
        localparam bit                 VX_NEG0 = (g % 2) != 0;

        life_t              st;
        logic signed [11:0] x;
        logic signed [11:0] y;
        logic               vx_neg;
        logic               vy_neg;
        logic [7:0]         cnt;
        logic signed [11:0] nx;
        logic signed [11:0] ny;

        assign nx = vx_neg ? (x - SPD_X) : (x + SPD_X);
        assign ny = vy_neg ? (y - SPD_Y) : (y + SPD_Y);

        // Life cycle, frame counter and bouncing motion of this ghost.
        always_ff @(posedge clk or negedge resetN) begin
            if (!resetN) begin
                st     <= ST_ALIVE;
                x      <= SPAWN_X;
                y      <= SPAWN_Y;
                vx_neg <= VX_NEG0;
                vy_neg <= 1'b0;
                cnt    <= '0;
            end else begin
                case (st)
                    ST_ALIVE: begin
                        // A collision wins over the frame's move.
                        if (bus.collision[g]) begin
                            st  <= ST_HIT;
                            cnt <= '0;
                        end else if (frame_tick) begin
                            if (nx < X_LO) begin
                                x      <= X_LO;
                                vx_neg <= 1'b0;
                            end else if (nx > X_HI) begin
                                x      <= X_HI;
                                vx_neg <= 1'b1;
                            end else begin
                                x <= nx;
                            end
                            if (ny < Y_LO) begin
                                y      <= Y_LO;
                                vy_neg <= 1'b0;
                            end else if (ny > Y_HI) begin
                                y      <= Y_HI;
                                vy_neg <= 1'b1;
                            end else begin
                                y <= ny;
                            end
                        end
                    end
                    ST_HIT: begin
                        if (frame_tick) begin
                            if (cnt == FLASH_LAST) begin
                                st  <= ST_DEAD;
                                cnt <= '0;
                            end else begin
                                cnt <= cnt + 8'd1;
                            end
                        end
                    end
                    ST_DEAD: begin
                        if (frame_tick) begin
                            if (cnt == DEAD_LAST) begin
                                st  <= ST_RESPAWN;
                                cnt <= '0;
                            end else begin
                                cnt <= cnt + 8'd1;
                            end
                        end
                    end
                    default: begin
                        st     <= ST_ALIVE;
                        x      <= SPAWN_X;
                        y      <= SPAWN_Y;
                        vx_neg <= VX_NEG0;
                        vy_neg <= 1'b0;
                        cnt    <= '0;
                    end
                endcase
            end
        end

        assign hit[g] = ((st == ST_ALIVE) || (st == ST_HIT)) &&
                        (px >= x) && (px < x + W_S) &&
                        (py >= y) && (py < y + H_S);
        assign lx_w[g]  = 10'(px - x);
        assign ly_w[g]  = 9'(py - y);
        // Bit 2 of the HIT counter toggles every four frames: the flash.
        assign rgb_w[g] = ((st == ST_HIT) && cnt[2]) ? 12'hFFF : COLOR;
        assign state_dbg[2*g +: 2] = st;
    end

    logic        win;
    logic [2:0]  win_idx;
    logic [9:0]  win_lx;
    logic [8:0]  win_ly;
    logic [11:0] win_rgb;

    // Priority select: scanning downward lets the lowest hitting index win.
    always_comb begin
        win     = 1'b0;
        win_idx = '0;
        win_lx  = '0;
        win_ly  = '0;
        win_rgb = '0;
        for (int i = N_GHOSTS - 1; i >= 0; i--) begin
            if (hit[i]) begin
                win     = 1'b1;
                win_idx = 3'(i);
                win_lx  = lx_w[i];
                win_ly  = ly_w[i];
                win_rgb = rgb_w[i];
            end
        end
    end

    logic        draw_q;
    logic [2:0]  idx_q;
    logic [9:0]  lx_q;
    logic [8:0]  ly_q;
    logic [11:0] rgb_q;
    logic [9:0]  theta_q;

    // Registered pixel outputs; everything is zero when no ghost covers the pixel.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            draw_q <= 1'b0;
            idx_q  <= '0;
            lx_q   <= '0;
            ly_q   <= '0;
            rgb_q  <= '0;
        end else begin
            draw_q <= win;
            idx_q  <= win_idx;
            lx_q   <= win_lx;
            ly_q   <= win_ly;
            rgb_q  <= win_rgb;
        end
    end

    // Rotation angle, sampled once per frame so it stays stable while drawing.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            theta_q <= '0;
        end else if (bus.startOfFrame) begin
            theta_q <= 10'(({6'b0, bus.wheel} * 18'(WHEEL_MUL)) >> 7);
        end
    end

    assign bus.Draw        = draw_q;
    assign bus.ghost_idx   = idx_q;
    assign bus.local_x     = lx_q;
    assign bus.local_y     = ly_q;
    assign bus.Red         = rgb_q[11:8];
    assign bus.Green       = rgb_q[7:4];
    assign bus.Blue        = rgb_q[3:0];
    assign bus.theta       = theta_q;
    assign bus.ghost_state = state_dbg;

endmodule

// File: tb/tb_ghost_swarm_unit.sv
// Bench for ghost_swarm_unit: a frame-level model of the ghosts (positions,
// velocities, life cycle, theta) predicts every registered pixel output.
module tb_ghost_swarm_unit;
    localparam int N = 4;
    localparam int M_ALIVE   = 0;
    localparam int M_HIT     = 1;
    localparam int M_DEAD    = 2;
    localparam int M_RESPAWN = 3;

    logic clk;
    logic resetN;
    ghost_swarm_if #(.N_GHOSTS(N)) bus();

    ghost_swarm_unit #(.N_GHOSTS(N)) dut (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus)
    );

    int checks   = 0;
    int failures = 0;
    logic [44:0] exp_q[$];

    int mx[N], my[N], mvx[N], mvy[N], mst[N], mcnt[N];
    int mtheta;
    int drv_wheel;
    bit drv_freeze;

    // Clock and reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model
    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin
            mx[i]   = 32 + i * 128;
            my[i]   = 16;
            mvx[i]  = (i % 2 == 1) ? -2 : 2;
            mvy[i]  = 1;
            mst[i]  = M_ALIVE;
            mcnt[i] = 0;
        end
        mtheta = 0;
    endfunction

    function automatic logic [34:0] model_pixel(int px, int py);
        for (int i = 0; i < N; i++) begin
            if ((mst[i] == M_ALIVE || mst[i] == M_HIT) &&
                px >= mx[i] && px < mx[i] + 64 && py >= my[i] && py < my[i] + 64) begin
                logic [11:0] rgb;
                rgb = (mst[i] == M_HIT && ((mcnt[i] / 4) % 2 == 1)) ? 12'hFFF : 12'hF0F;
                return {1'b1, 3'(i), 10'(px - mx[i]), 9'(py - my[i]), rgb};
            end
        end
        return '0;
    endfunction

    function automatic void model_step(bit sof, logic [N-1:0] col);
        bit ft;
        int nx, ny;
        ft = sof && !drv_freeze;
        if (sof) mtheta = ((drv_wheel * 34) / 128) % 1024;
        for (int i = 0; i < N; i++) begin
            case (mst[i])
                M_ALIVE: begin
                    if (col[i]) begin
                        mst[i] = M_HIT; mcnt[i] = 0;
                    end else if (ft) begin
                        nx = mx[i] + mvx[i];
                        ny = my[i] + mvy[i];
                        if (nx < 0) begin mx[i] = 0; mvx[i] = 2; end
                        else if (nx > 576) begin mx[i] = 576; mvx[i] = -2; end
                        else mx[i] = nx;
                        if (ny < 0) begin my[i] = 0; mvy[i] = 1; end
                        else if (ny > 416) begin my[i] = 416; mvy[i] = -1; end
                        else my[i] = ny;
                    end
                end
                M_HIT: if (ft) begin
                    if (mcnt[i] == 15) begin mst[i] = M_DEAD; mcnt[i] = 0; end
                    else mcnt[i]++;
                end
                M_DEAD: if (ft) begin
                    if (mcnt[i] == 59) begin mst[i] = M_RESPAWN; mcnt[i] = 0; end
                    else mcnt[i]++;
                end
                default: begin
                    mst[i]  = M_ALIVE;
                    mx[i]   = 32 + i * 128;
                    my[i]   = 16;
                    mvx[i]  = (i % 2 == 1) ? -2 : 2;
                    mvy[i]  = 1;
                    mcnt[i] = 0;
                end
            endcase
        end
    endfunction

    // Driver: one clock with the given inputs; returns expected and observed
    // {Draw, idx, local_x, local_y, RGB, theta}.
    task automatic tick(input bit sof, input logic [N-1:0] col, input int px, input int py,
                        output logic [44:0] exp_v, output logic [44:0] obs_v);
        logic [34:0] pix;
        @(negedge clk);
        bus.startOfFrame = sof;
        bus.collision    = col;
        bus.pxl_x        = 11'(px);
        bus.pxl_y        = 11'(py);
        bus.wheel        = 12'(drv_wheel);
        bus.freeze       = drv_freeze;
        pix = model_pixel(px, py);
        model_step(sof, col);
        exp_q.push_back({pix, 10'(mtheta)});
        @(posedge clk);
        #1;
        obs_v = {bus.Draw, bus.ghost_idx, bus.local_x, bus.local_y,
                 bus.Red, bus.Green, bus.Blue, bus.theta};
        exp_v = exp_q.pop_front();
        bus.startOfFrame = 1'b0;
        bus.collision    = '0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        resetN = 1'b0;
        @(negedge clk);
        resetN = 1'b1;
        model_reset();
        exp_q.delete();
    endtask

    task automatic test_reset();
        logic [44:0] e, o;
        int pts[6][2] = '{'{160, 16}, '{31, 16}, '{95, 79}, '{96, 16}, '{33, 80}, '{223, 79}};
        @(negedge clk);
        bus.pxl_x = 11'd32;
        bus.pxl_y = 11'd16;
        resetN = 1'b0;
        @(posedge clk);
        #1;
        o = {bus.Draw, bus.ghost_idx, bus.local_x, bus.local_y, bus.Red, bus.Green, bus.Blue, bus.theta};
        checks++;
        if (o !== 45'd0) begin
            failures++;
            $display("FAIL reset_outputs: got %h expected 0", o);
        end
        @(negedge clk);
        resetN = 1'b1;
        model_reset();
        tick(0, '0, 32, 16, e, o);
        checks++;
        if (o !== {1'b1, 3'd0, 10'd0, 9'd0, 12'hF0F, 10'd0}) begin
            failures++;
            $display("FAIL reset_spawn0: got %h expected %h", o, {1'b1, 3'd0, 10'd0, 9'd0, 12'hF0F, 10'd0});
        end
        foreach (pts[k]) begin
            tick(0, '0, pts[k][0], pts[k][1], e, o);
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL reset_pixel(%0d,%0d): got %h expected %h", pts[k][0], pts[k][1], o, e);
            end
        end
    endtask

    task automatic test_theta();
        logic [44:0] e, o;
        apply_reset();
        drv_wheel = 1000;
        tick(1, '0, $urandom_range(0, 639), $urandom_range(0, 479), e, o);
        checks++;
        if (o[9:0] !== 10'd265 || o !== e) begin
            failures++;
            $display("FAIL theta_latch: got %h expected %h (theta 265)", o, e);
        end
        drv_wheel = 4000;
        tick(0, '0, 40, 20, e, o);
        checks++;
        if (o[9:0] !== 10'd265 || o !== e) begin
            failures++;
            $display("FAIL theta_hold: got %h expected %h (theta 265)", o, e);
        end
        tick(1, '0, 40, 20, e, o);
        checks++;
        if (o !== e) begin
            failures++;
            $display("FAIL theta_next: got %h expected %h", o, e);
        end
    endtask

    task automatic test_bounce();
        logic [44:0] e, o;
        apply_reset();
        drv_wheel = $urandom_range(0, 4095);
        for (int f = 0; f < 100; f++) begin
            tick(1, '0, $urandom_range(0, 700), $urandom_range(0, 500), e, o);
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL bounce_frame%0d: got %h expected %h", f, o, e);
            end
            tick(0, '0, mx[1], my[1], e, o);
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL bounce_g1_corner%0d: got %h expected %h", f, o, e);
            end
            if (mx[1] > 0) begin
                tick(0, '0, mx[1] - 1, my[1], e, o);
                checks++;
                if (o !== e) begin
                    failures++;
                    $display("FAIL bounce_g1_left%0d: got %h expected %h", f, o, e);
                end
            end
        end
        // Reached x=0 after frame 80, reversed at 81, so x=38 after frame 100.
        tick(0, '0, 38, 116, e, o);
        checks++;
        if ({o[44], o[43:41], o[40:31], o[30:22]} !== {1'b1, 3'd1, 10'd0, 9'd0}) begin
            failures++;
            $display("FAIL bounce_after_clamp: got %h expected draw=1 idx=1 local=(0,0)", o);
        end
    endtask

    task automatic test_hit();
        logic [44:0] e, o;
        apply_reset();
        tick(0, 4'b0001, 32, 16, e, o);
        checks++;
        if (o !== e) begin
            failures++;
            $display("FAIL hit_enter: got %h expected %h", o, e);
        end
        for (int k = 1; k <= 16; k++) begin
            tick(1, '0, $urandom_range(0, 639), $urandom_range(0, 479), e, o);
            tick(0, '0, 32, 16, e, o);
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL hit_flash%0d: got %h expected %h", k, o, e);
            end
            if (k == 5 || k == 2) begin
                checks++;
                if (o[21:10] !== ((k == 5) ? 12'hFFF : 12'hF0F) || o[40:22] !== 19'd0) begin
                    failures++;
                    $display("FAIL hit_colour%0d: got %h expected rgb %h at local (0,0)", k, o,
                             (k == 5) ? 12'hFFF : 12'hF0F);
                end
            end
        end
        for (int k = 1; k <= 60; k++) begin
            tick(1, '0, $urandom_range(0, 639), $urandom_range(0, 479), e, o);
            tick(0, '0, 32, 16, e, o);
            checks++;
            if (o !== e || o[44] !== 1'b0) begin
                failures++;
                $display("FAIL dead_hidden%0d: got %h expected %h", k, o, e);
            end
        end
        tick(0, '0, 32, 16, e, o);
        checks++;
        if (o[44:10] !== {1'b1, 3'd0, 10'd0, 9'd0, 12'hF0F} || o !== e) begin
            failures++;
            $display("FAIL respawn: got %h expected %h", o, e);
        end
    endtask

    task automatic test_overlap();
        logic [44:0] e, o;
        bit found;
        int ox, oy;
        apply_reset();
        found = 0;
        for (int f = 0; f < 300 && !found; f++) begin
            tick(1, '0, $urandom_range(0, 639), $urandom_range(0, 479), e, o);
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL overlap_frame%0d: got %h expected %h", f, o, e);
            end
            if (my[0] == my[2] && mx[0] - mx[2] < 64 && mx[2] - mx[0] < 64) begin
                found = 1;
                tick(0, '0, ((mx[0] > mx[2]) ? mx[0] : mx[2]) + 1, my[0] + 1, e, o);
                checks++;
                if (o[44:41] !== {1'b1, 3'd0} || o !== e) begin
                    failures++;
                    $display("FAIL overlap_priority: got %h expected %h idx 0", o, e);
                end
            end
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL overlap_reached: got 0 expected 1");
        end
        ox = mx[0];
        oy = my[0];
        tick(1, 4'b0001, ox, oy, e, o);
        checks++;
        if (o !== e) begin
            failures++;
            $display("FAIL overlap_hit_sof: got %h expected %h", o, e);
        end
        tick(0, '0, ox, oy, e, o);
        checks++;
        if (o[44:22] !== {1'b1, 3'd0, 10'd0, 9'd0} || o !== e) begin
            failures++;
            $display("FAIL hit_no_move: got %h expected %h", o, e);
        end
    endtask

    task automatic test_freeze();
        logic [44:0] e, o;
        apply_reset();
        tick(0, 4'b0001, 32, 16, e, o);
        for (int k = 0; k < 5; k++) tick(1, '0, 32, 16, e, o);
        drv_freeze = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick(1, '0, $urandom_range(0, 639), $urandom_range(0, 479), e, o);
            tick(0, '0, 32, 16, e, o);
            checks++;
            if (o[44:10] !== {1'b1, 3'd0, 10'd0, 9'd0, 12'hFFF} || o !== e) begin
                failures++;
                $display("FAIL freeze_hit%0d: got %h expected %h", k, o, e);
            end
            tick(0, '0, mx[1], my[1], e, o);
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL freeze_g1_%0d: got %h expected %h", k, o, e);
            end
        end
        drv_freeze = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick(1, '0, 32, 16, e, o);
            tick(0, '0, 32, 16, e, o);
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL unfreeze%0d: got %h expected %h", k, o, e);
            end
        end
        tick(0, '0, mx[1], my[1], e, o);
        #2;
        resetN = 1'b0;
        #1;
        o = {bus.Draw, bus.ghost_idx, bus.local_x, bus.local_y, bus.Red, bus.Green, bus.Blue, bus.theta};
        checks++;
        if (o !== 45'd0) begin
            failures++;
            $display("FAIL midframe_reset: got %h expected 0", o);
        end
        @(negedge clk);
        resetN = 1'b1;
        model_reset();
        tick(0, '0, 32, 16, e, o);
        checks++;
        if (o !== e) begin
            failures++;
            $display("FAIL post_reset_g0: got %h expected %h", o, e);
        end
        tick(0, '0, 160, 16, e, o);
        checks++;
        if (o !== e) begin
            failures++;
            $display("FAIL post_reset_g1: got %h expected %h", o, e);
        end
    endtask

    task automatic test_random();
        logic [44:0] e, o;
        logic [N-1:0] col;
        int g, px, py;
        apply_reset();
        for (int f = 0; f < 300; f++) begin
            drv_freeze = ($urandom_range(0, 7) == 0);
            drv_wheel  = $urandom_range(0, 4095);
            for (int i = 0; i < N; i++) col[i] = ($urandom_range(0, 39) == 0);
            tick(1, col, $urandom_range(0, 700), $urandom_range(0, 500), e, o);
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL random_sof%0d: got %h expected %h", f, o, e);
            end
            for (int p = 0; p < 3; p++) begin
                g  = $urandom_range(0, N - 1);
                px = mx[g] + $urandom_range(0, 70) - 3;
                py = my[g] + $urandom_range(0, 70) - 3;
                if (px < 0) px = 0;
                if (py < 0) py = 0;
                for (int i = 0; i < N; i++) col[i] = ($urandom_range(0, 99) == 0);
                tick(0, col, px, py, e, o);
                checks++;
                if (o !== e) begin
                    failures++;
                    $display("FAIL random_pix%0d_%0d: got %h expected %h", f, p, o, e);
                end
            end
        end
        drv_freeze = 1'b0;
    endtask

    initial begin
        bus.startOfFrame = 1'b0;
        bus.freeze       = 1'b0;
        bus.collision    = '0;
        bus.pxl_x        = '0;
        bus.pxl_y        = '0;
        bus.wheel        = '0;
        drv_wheel        = 0;
        drv_freeze       = 1'b0;
        resetN           = 1'b1;
        model_reset();
        #2;
        resetN = 1'b0;
        test_reset();
        test_theta();
        test_bounce();
        test_hit();
        test_overlap();
        test_freeze();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
